ble_packet_tx: RTL

BLE_PACKET_TX -- requirements
Module: ble_packet_tx

---
 rtl/ble_pkg.sv | 37 +++
 rtl/uart_tx.sv | 96 +++++++++
 rtl/ble_packet_tx.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ble_pkg.sv
// Shared constants, state encodings and helpers for the BLE packet transmitter.
package ble_pkg;

  localparam int DEF_CLK_FREQ = 100_000_000;
  localparam int DEF_BAUD     = 115_200;

  localparam logic [7:0] NEWLINE    = 8'h0A;
  localparam logic [7:0] SUBST_BYTE = 8'h0B;

  // Packet sequencer states
  typedef enum logic [2:0] {
    TS_IDLE      = 3'd0,
    TS_LOAD_BYTE = 3'd1,
    TS_WAIT_BYTE = 3'd2,
    TS_SEND_NL   = 3'd3,
    TS_WAIT_NL   = 3'd4,
    TS_FINISH    = 3'd5
  } top_state_t;

  // UART character engine states
  typedef enum logic [1:0] {
    US_IDLE  = 2'd0,
    US_START = 2'd1,
    US_DATA  = 2'd2,
    US_STOP  = 2'd3
  } uart_state_t;

  // A payload byte must never look like the frame terminator on the wire
  function automatic logic [7:0] subst_byte(input logic [7:0] b);
    if (b == NEWLINE) begin
      return SUBST_BYTE;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, one character per start request.
module uart_tx
  import ble_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD     = DEF_BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       ready
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_t      state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             txd_r;
  logic             ready_r;

  assign txd   = txd_r;
  assign ready = ready_r;

  // Character FSM: each bit is held for exactly CLKS_PER_BIT cycles via a down-counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= US_IDLE;
      cnt_r     <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      txd_r     <= 1'b1;
      ready_r   <= 1'b1;
    end else begin
      case (state_r)
        US_IDLE: begin
          txd_r <= 1'b1;
          if (start) begin
            shift_r <= data;
            txd_r   <= 1'b0;
            cnt_r   <= CNT_TOP;
            ready_r <= 1'b0;
            state_r <= US_START;
          end else begin
            ready_r <= 1'b1;
          end
        end
        US_START: begin
          if (cnt_r == '0) begin
            txd_r     <= shift_r[0];
            shift_r   <= {1'b0, shift_r[7:1]};
            bit_idx_r <= 3'd0;
            cnt_r     <= CNT_TOP;
            state_r   <= US_DATA;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        US_DATA: begin
          if (cnt_r == '0) begin
            cnt_r <= CNT_TOP;
            if (bit_idx_r == 3'd7) begin
              txd_r   <= 1'b1;
              state_r <= US_STOP;
            end else begin
              txd_r     <= shift_r[0];
              shift_r   <= {1'b0, shift_r[7:1]};
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        US_STOP: begin
          if (cnt_r == '0) begin
            ready_r <= 1'b1;
            state_r <= US_IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= US_IDLE;
          txd_r   <= 1'b1;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/ble_packet_tx.sv
// Sends a snapshot of PAYLOAD_LEN bytes followed by a newline over UART to a BLE module.
module ble_packet_tx
  import ble_pkg::*;
#(
  parameter int CLK_FREQ    = DEF_CLK_FREQ,
  parameter int BAUD        = DEF_BAUD,
  parameter int PAYLOAD_LEN = 11
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        send,
  input  logic [PAYLOAD_LEN-1:0][7:0] payload,
  output logic                        busy,
  output logic                        done,
  output logic                        subst,
  output logic                        txd
);

  localparam int IDX_W = $clog2(PAYLOAD_LEN + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_LEN - 1);

  top_state_t                  state_r;
  logic [IDX_W-1:0]            idx_r;
  logic [PAYLOAD_LEN-1:0][7:0] snap_r;
  logic                        busy_r;
  logic                        done_r;
  logic                        subst_r;

  logic       uart_start_s;
  logic [7:0] uart_data_s;
  logic       uart_ready_s;
  logic [7:0] cur_byte_s;

  assign busy  = busy_r;
  assign done  = done_r;
  assign subst = subst_r;

  // Hand the UART the next character in the same cycle it reports ready
  always_comb begin
    uart_start_s = 1'b0;
    uart_data_s  = NEWLINE;
    cur_byte_s   = snap_r[idx_r];
    case (state_r)
      TS_LOAD_BYTE: begin
        uart_start_s = uart_ready_s;
        uart_data_s  = subst_byte(cur_byte_s);
      end
      TS_SEND_NL: begin
        uart_start_s = uart_ready_s;
        uart_data_s  = NEWLINE;
      end
      default: begin
        uart_start_s = 1'b0;
        uart_data_s  = NEWLINE;
      end
    endcase
  end

  // Packet sequencer; subst is raised on the same edge the UART launches the start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= TS_IDLE;
      idx_r   <= '0;
      snap_r  <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      subst_r <= 1'b0;
    end else begin
      subst_r <= 1'b0;
      case (state_r)
        TS_IDLE: begin
          done_r <= 1'b0;
          if (send) begin
            snap_r  <= payload;
            idx_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= TS_LOAD_BYTE;
          end else begin
            busy_r <= 1'b0;
          end
        end
        TS_LOAD_BYTE: begin
          if (uart_ready_s) begin
            subst_r <= (cur_byte_s == NEWLINE);
            state_r <= TS_WAIT_BYTE;
          end else begin
            state_r <= TS_LOAD_BYTE;
          end
        end
        TS_WAIT_BYTE: begin
          if (uart_ready_s) begin
            if (idx_r == LAST_IDX) begin
              state_r <= TS_SEND_NL;
            end else begin
              idx_r   <= idx_r + IDX_W'(1);
              state_r <= TS_LOAD_BYTE;
            end
          end else begin
            state_r <= TS_WAIT_BYTE;
          end
        end
        TS_SEND_NL: begin
          if (uart_ready_s) begin
            state_r <= TS_WAIT_NL;
          end else begin
            state_r <= TS_SEND_NL;
          end
        end
        TS_WAIT_NL: begin
          if (uart_ready_s) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= TS_FINISH;
          end else begin
            state_r <= TS_WAIT_NL;
          end
        end
        TS_FINISH: begin
          done_r  <= 1'b0;
          state_r <= TS_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= TS_IDLE;
        end
      endcase
    end
  end

  uart_tx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) u_uart (
    .clk  (clk),
    .rst_n(rst_n),
    .start(uart_start_s),
    .data (uart_data_s),
    .txd  (txd),
    .ready(uart_ready_s)
  );

endmodule
